// File: rtl/obuft_drive_sequencer_if.sv
// ---------------------------------------------------------------------------
// obuft_drive_sequencer_if
// Bus between a word producer and the tri-state pad serializer.
//   DIN      word to transmit            (producer -> sequencer)
//   DIN_VLD  DIN valid                   (producer -> sequencer)
//   DIN_RDY  sequencer can take a word   (sequencer -> producer)
//   ABORT    terminate current transfer  (producer -> sequencer)
//   O_I      pad buffer data input       (sequencer -> pad)
//   O_T      pad buffer tristate, 1=Z    (sequencer -> pad)
//   BUSY     sequencer not idle          (sequencer -> producer)
//   DONE     one-cycle word-complete     (sequencer -> producer)
// ---------------------------------------------------------------------------
interface obuft_drive_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] DIN;
    logic             DIN_VLD;
    logic             DIN_RDY;
    logic             ABORT;
    logic             O_I;
    logic             O_T;
    logic             BUSY;
    logic             DONE;

    modport master (
        output DIN, DIN_VLD, ABORT,
        input  DIN_RDY, O_I, O_T, BUSY, DONE
    );

    modport slave (
        input  DIN, DIN_VLD, ABORT,
        output DIN_RDY, O_I, O_T, BUSY, DONE
    );
endinterface

// File: rtl/obuft_drive_sequencer.sv
// ---------------------------------------------------------------------------
// obuft_drive_sequencer
// Serializes parallel words onto a tri-state output buffer. On accept the pad
// is enabled, held at IDLE_LVL for LEAD_CYC cycles, then the word is shifted
// out LSB first. Afterwards the pad is released for at least TURN_CYC cycles
// before it may be driven again. A word accepted on the last-bit cycle
// continues the drive window with no gap.
// Ports:
//   C      clock, rising edge
//   CLR_N  asynchronous active-low reset
//   bus    slave side of obuft_drive_sequencer_if (handshake + pad outputs)
// O_I, O_T and DONE are registered; DIN_RDY and BUSY are decoded from state.
// ---------------------------------------------------------------------------
module obuft_drive_sequencer #(
    parameter int   WIDTH    = 8,
    parameter int   LEAD_CYC = 1,
    parameter int   TURN_CYC = 2,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic                      C,
    input  logic                      CLR_N,
    obuft_drive_sequencer_if.slave    bus
);
    // Counter serves as bit index in SHIFT and as cycle count in LEAD/TURN.
    localparam int CW = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TURN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             o_i_q, o_i_d;
    logic             o_t_q, o_t_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             accept;

    // cnt_q holds the index of the bit currently on O_I while in SHIFT.
    assign last_bit    = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
    assign bus.DIN_RDY = ((state_q == IDLE) || last_bit) && !bus.ABORT;
    assign accept      = bus.DIN_RDY && bus.DIN_VLD;

    assign bus.O_I  = o_i_q;
    assign bus.O_T  = o_t_q;
    assign bus.DONE = done_q;
    assign bus.BUSY = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        o_i_d   = o_i_q;
        o_t_d   = o_t_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    o_t_d = 1'b0;
                    if (LEAD_CYC > 0) begin
                        state_d = LEAD;
                        sh_d    = bus.DIN;
                        o_i_d   = IDLE_LVL;
                    end else begin
                        // Bit 0 goes straight to O_I; the register keeps the rest.
                        state_d = SHIFT;
                        sh_d    = bus.DIN >> 1;
                        o_i_d   = bus.DIN[0];
                    end
                end
            end
            LEAD: begin
                if (bus.ABORT) begin
                    state_d = TURN;
                    cnt_d   = '0;
                    sh_d    = '0;
                    o_t_d   = 1'b1;
                    o_i_d   = IDLE_LVL;
                end else if (cnt_q == CW'(LEAD_CYC - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    o_i_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    // Word is complete even if ABORT is high now.
                    done_d = 1'b1;
                    if (accept) begin
                        cnt_d = '0;
                        o_i_d = bus.DIN[0];
                        sh_d  = bus.DIN >> 1;
                    end else begin
                        state_d = TURN;
                        cnt_d   = '0;
                        o_t_d   = 1'b1;
                        o_i_d   = IDLE_LVL;
                    end
                end else if (bus.ABORT) begin
                    state_d = TURN;
                    cnt_d   = '0;
                    sh_d    = '0;
                    o_t_d   = 1'b1;
                    o_i_d   = IDLE_LVL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    o_i_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                end
            end
            TURN: begin
                if (cnt_q == CW'(TURN_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                o_t_d   = 1'b1;
                o_i_d   = IDLE_LVL;
            end
        endcase
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            o_i_q   <= IDLE_LVL;
            o_t_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            o_i_q   <= o_i_d;
            o_t_q   <= o_t_d;
            done_q  <= done_d;
        end
    end
endmodule
